// File: rtl/sc_regentry_tracker_if.sv
// Goal-row entry tracker bus: frog position and restart in, entry status out.
interface sc_regentry_tracker_if;
  logic       SC_RegENTRY_clear_InLow;
  logic [2:0] SC_RegENTRY_frogRow_In;
  logic [2:0] SC_RegENTRY_frogCol_In;
  logic [1:0] SC_RegENTRY_numEntry_Out;
  logic       SC_RegENTRY_chgEntry_OutLow;
  logic [2:0] SC_RegENTRY_entryMap_Out;
  logic       SC_RegENTRY_frogReset_OutLow;
  logic       SC_RegENTRY_hitWall_OutLow;

  // Game side: drives position and restart, observes entry status.
  modport master (
    output SC_RegENTRY_clear_InLow,
    output SC_RegENTRY_frogRow_In,
    output SC_RegENTRY_frogCol_In,
    input  SC_RegENTRY_numEntry_Out,
    input  SC_RegENTRY_chgEntry_OutLow,
    input  SC_RegENTRY_entryMap_Out,
    input  SC_RegENTRY_frogReset_OutLow,
    input  SC_RegENTRY_hitWall_OutLow
  );

  // Tracker side.
  modport slave (
    input  SC_RegENTRY_clear_InLow,
    input  SC_RegENTRY_frogRow_In,
    input  SC_RegENTRY_frogCol_In,
    output SC_RegENTRY_numEntry_Out,
    output SC_RegENTRY_chgEntry_OutLow,
    output SC_RegENTRY_entryMap_Out,
    output SC_RegENTRY_frogReset_OutLow,
    output SC_RegENTRY_hitWall_OutLow
  );
endinterface

// File: rtl/sc_regentry_tracker.sv
// Frogger goal-row entry tracker: records which of three goal entries are
// filled, pulses a change strobe to the level register on each new fill,
// asks the frog register to send the frog home, and flags bad landings.
module sc_regentry_tracker #(
  parameter logic [2:0] TOP_ROW    = 3'd0,
  parameter logic [2:0] ENTRY_COL0 = 3'd1,
  parameter logic [2:0] ENTRY_COL1 = 3'd3,
  parameter logic [2:0] ENTRY_COL2 = 3'd5
) (
  input logic                  SC_RegENTRY_CLOCK_50,
  input logic                  SC_RegENTRY_RESET_InLow,
  sc_regentry_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    WATCH  = 2'd0,
    STROBE = 2'd1,
    HOLD   = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  state_t     state_q;
  logic [2:0] map_q;
  logic [1:0] count_q;
  logic       chg_q;
  logic       frog_rst_q;
  logic       hit_q;

  logic       on_top;
  logic [2:0] col_hit;
  logic [2:0] fresh;
  logic       new_entry;
  logic       bad_landing;

  // Decode the frog position against the goal row and the unfilled entries.
  always_comb begin
    on_top      = (bus.SC_RegENTRY_frogRow_In == TOP_ROW);
    col_hit[0]  = (bus.SC_RegENTRY_frogCol_In == ENTRY_COL0);
    col_hit[1]  = (bus.SC_RegENTRY_frogCol_In == ENTRY_COL1);
    col_hit[2]  = (bus.SC_RegENTRY_frogCol_In == ENTRY_COL2);
    fresh       = col_hit & ~map_q;
    new_entry   = on_top && (fresh != 3'b000);
    bad_landing = on_top && (fresh == 3'b000);
  end

  // Entry FSM with registered strobes; restart wins over any arrival.
  always_ff @(posedge SC_RegENTRY_CLOCK_50) begin
    if (!SC_RegENTRY_RESET_InLow || !bus.SC_RegENTRY_clear_InLow) begin
      state_q    <= WATCH;
      map_q      <= 3'b000;
      count_q    <= 2'd0;
      chg_q      <= 1'b1;
      frog_rst_q <= 1'b1;
      hit_q      <= 1'b1;
    end else begin
      // Both strobes are single-cycle; they only go low on the WATCH exit.
      chg_q <= 1'b1;
      hit_q <= 1'b1;
      case (state_q)
        WATCH: begin
          if (new_entry) begin
            map_q      <= map_q | fresh;
            count_q    <= count_q + 2'd1;
            chg_q      <= 1'b0;
            frog_rst_q <= 1'b0;
            state_q    <= STROBE;
          end else if (bad_landing) begin
            hit_q      <= 1'b0;
            frog_rst_q <= 1'b0;
            state_q    <= HOLD;
          end
        end
        STROBE: begin
          frog_rst_q <= 1'b0;
          state_q    <= HOLD;
        end
        HOLD: begin
          // Wait for the frog register to move the frog off the goal row.
          if (!on_top) begin
            frog_rst_q <= 1'b1;
            state_q    <= (count_q == 2'd3) ? CLEAR : WATCH;
          end
        end
        CLEAR: begin
          // Count 3 stays visible through this cycle, then the row empties.
          map_q      <= 3'b000;
          count_q    <= 2'd0;
          frog_rst_q <= 1'b1;
          state_q    <= WATCH;
        end
        default: begin
          state_q    <= WATCH;
          frog_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.SC_RegENTRY_numEntry_Out     = count_q;
  assign bus.SC_RegENTRY_entryMap_Out     = map_q;
  assign bus.SC_RegENTRY_chgEntry_OutLow  = chg_q;
  assign bus.SC_RegENTRY_frogReset_OutLow = frog_rst_q;
  assign bus.SC_RegENTRY_hitWall_OutLow   = hit_q;

endmodule

// File: doc/sc_regentry_tracker.md
Name: sc_regentry_tracker

Overview:
- Entry-slot tracker for the Frogger goal row.
- Watches the frog position and marks which of the three goal entries are filled.
- Drives the filled-entry count plus a one-cycle active-low change strobe into the level register, so three filled entries advance the level exactly once.
- Also asks the frog register to return the frog to its start position, and flags landings on the goal row that are not valid entries.

Parameters:
- TOP_ROW, 3'd0: row index of the goal row.
- ENTRY_COL0, 3'd1: column of entry 0.
- ENTRY_COL1, 3'd3: column of entry 1.
- ENTRY_COL2, 3'd5: column of entry 2.

Ports:
- SC_RegENTRY_CLOCK_50  in  1  system clock; everything is on the rising edge.
- SC_RegENTRY_RESET_InLow  in  1  reset, synchronous, active-low.
- SC_RegENTRY_clear_InLow  in  1  game restart, synchronous, active-low; empties the map and count.
- SC_RegENTRY_frogRow_In  in  3  current frog row.
- SC_RegENTRY_frogCol_In  in  3  current frog column.
- SC_RegENTRY_numEntry_Out  out  2  number of filled entries, 0..3.
- SC_RegENTRY_chgEntry_OutLow  out  1  one-cycle low strobe when an entry is filled.
- SC_RegENTRY_entryMap_Out  out  3  filled-entry bitmap; bit k = entry k.
- SC_RegENTRY_frogReset_OutLow  out  1  low = frog register must return the frog to start.
- SC_RegENTRY_hitWall_OutLow  out  1  one-cycle low strobe on an invalid goal-row landing.

Behaviour:
- Clock and reset: single clock domain. RESET_InLow=0 is sampled on the clock edge; there is no asynchronous path.
- Reset values:
  - state = WATCH, count = 0, map = 3'b000;
  - chgEntry_OutLow = 1, frogReset_OutLow = 1, hitWall_OutLow = 1.
- Output decoding:
  - all outputs come from registers or state only, with no combinational path from the inputs;
  - numEntry_Out = count register and entryMap_Out = map register.
- State machine (WATCH, STROBE, HOLD, CLEAR):
  - WATCH, frog on a valid new entry: frogRow==TOP_ROW and frogCol equals ENTRY_COLk with map[k]==0. Set map[k], count <= count+1, go to STROBE.
  - WATCH, invalid landing: frogRow==TOP_ROW and frogCol is either not an entry column or an already-filled entry. Map and count are unchanged; go to HOLD via the one-cycle hitWall path (hitWall_OutLow=0 for exactly the first HOLD cycle).
  - WATCH, any other position: stay in WATCH.
  - STROBE: lasts exactly one cycle. chgEntry_OutLow=0, frogReset_OutLow=0, and numEntry_Out already shows the new count. Next state is HOLD.
  - HOLD: frogReset_OutLow=0 and chgEntry_OutLow=1. Stay while frogRow==TOP_ROW. When the frog leaves the row, go to CLEAR if count==3, else to WATCH.
  - CLEAR: one cycle. map <= 0, count <= 0, frogReset_OutLow=1. Next state is WATCH.
- Latency: a qualifying position sampled at edge N gives chgEntry_OutLow low from edge N until edge N+1.
- Spacing guarantee: two strobes are always separated by at least 2 cycles with chgEntry high, because HOLD is minimum 1 cycle and the next arrival is resampled in WATCH. The level register's one-shot guard therefore re-arms between strobes.
- Count=3 visibility:
  - numEntry_Out = 3 is visible during the STROBE cycle, so the level register increments exactly once;
  - the value 3 stays through HOLD and returns to 0 only after CLEAR.
- Width: count is 2 bits and never exceeds 3; the only path to 3 is three distinct map bits, so it never wraps.
- Priority: RESET_InLow > clear_InLow > FSM.
  - clear_InLow=0 forces state=WATCH, map=0, count=0 and all strobes high in the next cycle, from any state.
  - This holds even in the same cycle as an arrival: the arrival is ignored.
- Frog parked on the goal row after reset or clear: treated as a fresh arrival in WATCH. The frog register owns moving it.
- Reset or clear mid-STROBE or mid-HOLD: the strobe is aborted, outputs go to their reset values, and no partial count is kept.

Test Plan:
- Reset, frog at row 4: after releasing reset, numEntry=0, map=000, all _Low outputs=1 for 10 cycles.
- Frog to (0,1) for 3 cycles, then row 2:
  - chgEntry low for exactly 1 cycle with numEntry=1, map=001;
  - frogReset low from the strobe cycle until the cycle after row≠0.
- Fill cols 1, 3, 5 in sequence:
  - third strobe shows numEntry=3, map=111;
  - after the frog leaves, one CLEAR cycle, then numEntry=0, map=000;
  - paired level-register model increments exactly once, 1->2.
- Frog to (0,2), then to filled entry (0,1):
  - hitWall low for 1 cycle each time; map and count unchanged;
  - chgEntry stays high.
- Assert clear_InLow in the same cycle the frog reaches (0,3): map and count stay 0 and no strobe is issued. Repeat with RESET_InLow=0 during the STROBE cycle: chgEntry returns high next cycle.
